// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared widths, state encoding and strobe defaults for the MAR/MDR front end
package cpu_mem_pkg;

   localparam int ADDR_W        = 9;
   localparam int DATA_W        = 32;
   localparam int RD_CYCLES_DEF = 1;
   localparam int WR_CYCLES_DEF = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Counter width able to hold max_cycles-1 while staying at least one bit wide
   function automatic int cnt_width(input int max_cycles);
      return (max_cycles < 2) ? 1 : $clog2(max_cycles + 1);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU bus and RAM signal bundle for mem_access_ctrl
//  CPU side : bus_in, mar_ld, mdr_ld, rd_req, wr_req -> ctrl ; mdr_q, busy, done, proto_err <- ctrl
//  RAM side : ram_r, ram_w, ram_addr, ram_din <- ctrl ; ram_dout -> ctrl
//  slave  modport : the controller
//  master modport : the datapath/control unit plus RAM
interface mem_access_ctrl_if;
   import cpu_mem_pkg::*;

   logic [DATA_W-1:0] bus_in;
   logic              mar_ld;
   logic              mdr_ld;
   logic              rd_req;
   logic              wr_req;
   logic [DATA_W-1:0] mdr_q;
   logic              busy;
   logic              done;
   logic              proto_err;
   logic              ram_r;
   logic              ram_w;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   modport slave (
      input  bus_in, mar_ld, mdr_ld, rd_req, wr_req, ram_dout,
      output mdr_q, busy, done, proto_err, ram_r, ram_w, ram_addr, ram_din
   );

   modport master (
      output bus_in, mar_ld, mdr_ld, rd_req, wr_req, ram_dout,
      input  mdr_q, busy, done, proto_err, ram_r, ram_w, ram_addr, ram_din
   );

endinterface

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable down-counter timing how long a RAM strobe is held
//  clock, clear_n : clock and asynchronous active-low reset
//  i_load/i_load_val : load the count (has priority over decrement)
//  i_dec          : decrement, saturating at zero
//  o_zero         : count is zero
module mem_wait_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR front end running single read/write transactions on the RAM
//  clock, clear_n : clock and asynchronous active-low reset
//  bus (slave)    : CPU bus loads/requests, MDR/status back to CPU, RAM strobes/addr/data
//  RD_CYCLES / WR_CYCLES : cycles the read / write strobe is held (>=1)
module mem_access_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int RD_CYCLES = RD_CYCLES_DEF,
   parameter int WR_CYCLES = WR_CYCLES_DEF
) (
   input  logic              clock,
   input  logic              clear_n,
   mem_access_ctrl_if.slave  bus
);

   localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int CNT_W   = cnt_width(MAX_CYC);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_mar;
   logic [DATA_W-1:0] r_mdr;
   logic              r_ram_r;
   logic              r_ram_w;
   logic              r_proto_err;

   logic              w_ram_r_nxt;
   logic              w_ram_w_nxt;
   logic              w_proto_err_nxt;
   logic              w_cnt_load;
   logic [CNT_W-1:0]  w_cnt_load_val;
   logic              w_cnt_dec;
   logic              w_cnt_zero;
   logic              w_mdr_cap;
   logic              w_idle;

   assign w_idle = (r_state == IDLE);

   mem_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait (
      .clock      (clock),
      .clear_n    (clear_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_ram_r_nxt     = r_ram_r;
      w_ram_w_nxt     = r_ram_w;
      w_proto_err_nxt = 1'b0;
      w_cnt_load      = 1'b0;
      w_cnt_load_val  = RD_LOAD;
      w_cnt_dec       = 1'b0;
      w_mdr_cap       = 1'b0;
      case (r_state)
         IDLE: begin
            // Read wins a simultaneous request; the write is dropped and flagged
            if (bus.rd_req) begin
               w_state_nxt     = RD;
               w_ram_r_nxt     = 1'b1;
               w_cnt_load      = 1'b1;
               w_cnt_load_val  = RD_LOAD;
               w_proto_err_nxt = bus.wr_req;
            end else if (bus.wr_req) begin
               w_state_nxt    = WR;
               w_ram_w_nxt    = 1'b1;
               w_cnt_load     = 1'b1;
               w_cnt_load_val = WR_LOAD;
            end
         end
         RD: begin
            w_proto_err_nxt = bus.rd_req | bus.wr_req;
            if (w_cnt_zero) begin
               w_mdr_cap   = 1'b1;
               w_ram_r_nxt = 1'b0;
               w_state_nxt = DONE;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         WR: begin
            w_proto_err_nxt = bus.rd_req | bus.wr_req;
            if (w_cnt_zero) begin
               w_ram_w_nxt = 1'b0;
               w_state_nxt = DONE;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         DONE: begin
            w_proto_err_nxt = bus.rd_req | bus.wr_req;
            w_state_nxt     = IDLE;
         end
         default: begin
            w_ram_r_nxt = 1'b0;
            w_ram_w_nxt = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state     <= IDLE;
         r_ram_r     <= 1'b0;
         r_ram_w     <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ram_r     <= w_ram_r_nxt;
         r_ram_w     <= w_ram_w_nxt;
         r_proto_err <= w_proto_err_nxt;
      end
   end

   // MAR/MDR only load in IDLE so the RAM sees stable addr/din for the whole strobe
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_mar <= '0;
      end else if (w_idle && bus.mar_ld) begin
         r_mar <= bus.bus_in[ADDR_W-1:0];
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_mdr <= '0;
      end else if (w_mdr_cap) begin
         r_mdr <= bus.ram_dout;
      end else if (w_idle && bus.mdr_ld) begin
         r_mdr <= bus.bus_in;
      end
   end

   assign bus.mdr_q     = r_mdr;
   assign bus.busy      = !w_idle;
   assign bus.done      = (r_state == DONE);
   assign bus.proto_err = r_proto_err;
   assign bus.ram_r     = r_ram_r;
   assign bus.ram_w     = r_ram_w;
   assign bus.ram_addr  = r_mar;
   assign bus.ram_din   = r_mdr;

endmodule
